// File: rtl/rgb_pwm_pkg.sv
// rgb_pwm_driver shared types, defaults and the optional gamma map.
// RGB_PWM_GAMMA_EN: when defined, rgb_gamma() is provided.
package rgb_pwm_pkg;

  localparam int RGB_PWM_BITS_DEF = 8;
  localparam int RGB_PRESCALE_DEF = 47;

  // Storage width for duties; PWM_BITS must not exceed it.
  localparam int RGB_DUTY_W = 16;
  localparam int RGB_PROD_W = 2 * RGB_DUTY_W;

  typedef logic [RGB_DUTY_W-1:0] duty_t;

  typedef struct packed {
    duty_t r;
    duty_t g;
    duty_t b;
  } rgb_duty_t;

`ifdef RGB_PWM_GAMMA_EN
  // (x*x + 2^bits-1) >> bits; rounds up so 1 stays 1 and max stays max.
  function automatic duty_t rgb_gamma(input duty_t x, input int bits);
    logic [RGB_PROD_W-1:0] p;
    logic [RGB_PROD_W-1:0] bias;
    bias = (RGB_PROD_W'(1) << bits) - RGB_PROD_W'(1);
    p = RGB_PROD_W'(x) * RGB_PROD_W'(x) + bias;
    p = p >> bits;
    return p[RGB_DUTY_W-1:0];
  endfunction
`endif

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: active duty register, compare, registered
// active-low pin. Ports: clk, rst, load_i, duty_i, cnt_i, pin_o.
module pwm_channel
  import rgb_pwm_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load_i,
  input  duty_t duty_i,
  input  duty_t cnt_i,
  output logic  pin_o
);

  duty_t duty_q;
  logic  pin_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      duty_q <= '0;
      pin_q  <= 1'b1;
    end else begin
      if (load_i) begin
        duty_q <= duty_i;
      end
      pin_q <= !(cnt_i < duty_q);
    end
  end

  assign pin_o = pin_q;

endmodule

// File: rtl/rgb_pwm_driver.sv
// Double-buffered 3-channel PWM driver for an active-low RGB LED.
// Ports: clk, rst, in_valid/in_ready, r_in/g_in/b_in, frame_start,
// RGB_R/G/B. Define RGB_PWM_GAMMA_EN to gamma-map duties on transfer.
module rgb_pwm_driver
  import rgb_pwm_pkg::*;
#(
  parameter int PWM_BITS = RGB_PWM_BITS_DEF,
  parameter int PRESCALE = RGB_PRESCALE_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PWM_BITS-1:0] r_in,
  input  logic [PWM_BITS-1:0] g_in,
  input  logic [PWM_BITS-1:0] b_in,
  output logic                frame_start,
  output logic                RGB_R,
  output logic                RGB_G,
  output logic                RGB_B
);

  localparam int PRE_W =
    (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE);
  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

  logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  rgb_duty_t           pend_q, pend_d;
  logic                pend_full_q, pend_full_d;
  logic                frame_q;

  logic      tick;
  logic      boundary;
  logic      accept;
  logic      load;
  rgb_duty_t xfer;
  duty_t     cnt_ext;

  assign tick     = (pre_cnt_q == PRE_MAX);
  assign boundary = tick && (pwm_cnt_q == CNT_MAX);
  assign in_ready = !pend_full_q && !rst;
  assign accept   = in_valid && in_ready;
  // Only a triple already pending at the boundary is applied;
  // one accepted on the boundary itself waits a full period.
  assign load     = boundary && pend_full_q;
  assign cnt_ext  = duty_t'(pwm_cnt_q);

  always_comb begin
    pre_cnt_d   = tick ? '0 : pre_cnt_q + PRE_W'(1);
    pwm_cnt_d   = pwm_cnt_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    if (tick) begin
      pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    end
    if (load) begin
      pend_full_d = 1'b0;
    end
    if (accept) begin
      pend_d.r    = duty_t'(r_in);
      pend_d.g    = duty_t'(g_in);
      pend_d.b    = duty_t'(b_in);
      pend_full_d = 1'b1;
    end
  end

`ifdef RGB_PWM_GAMMA_EN
  always_comb begin
    xfer   = pend_q;
    xfer.r = rgb_gamma(pend_q.r, PWM_BITS);
    xfer.g = rgb_gamma(pend_q.g, PWM_BITS);
    xfer.b = rgb_gamma(pend_q.b, PWM_BITS);
  end
`else
  assign xfer = pend_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_q   <= '0;
      pwm_cnt_q   <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      frame_q     <= 1'b0;
    end else begin
      pre_cnt_q   <= pre_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      frame_q     <= boundary;
    end
  end

  assign frame_start = frame_q;

  pwm_channel u_ch_r (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .duty_i (xfer.r),
    .cnt_i  (cnt_ext),
    .pin_o  (RGB_R)
  );

  pwm_channel u_ch_g (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .duty_i (xfer.g),
    .cnt_i  (cnt_ext),
    .pin_o  (RGB_G)
  );

  pwm_channel u_ch_b (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .duty_i (xfer.b),
    .cnt_i  (cnt_ext),
    .pin_o  (RGB_B)
  );

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Scoreboard bench for rgb_pwm_driver: per-period lit-cycle counts
// are queued at stimulus time and checked at each frame_start.
module tb_rgb_pwm_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, in_ready, frame_start;
  logic       RGB_R, RGB_G, RGB_B;
  logic [3:0] r_in, g_in, b_in;

  logic       rst8, v8, rdy8, fs8, r8o, g8o, b8o;
  logic [7:0] r8, g8, b8;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int p;
    int r;
    int g;
    int b;
  } exp_t;

  exp_t q[$];
  exp_t q8[$];

  rgb_pwm_driver #(.PWM_BITS(4), .PRESCALE(0)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .frame_start(frame_start),
    .RGB_R(RGB_R), .RGB_G(RGB_G), .RGB_B(RGB_B)
  );

  rgb_pwm_driver #(.PWM_BITS(8), .PRESCALE(0)) u8 (
    .clk(clk), .rst(rst8), .in_valid(v8), .in_ready(rdy8),
    .r_in(r8), .g_in(g8), .b_in(b8),
    .frame_start(fs8),
    .RGB_R(r8o), .RGB_G(g8o), .RGB_B(b8o)
  );

  // Cycle 0 = first cycle after reset release (pwm_cnt = 0).
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic int gm(input int d, input int bits);
`ifdef RGB_PWM_GAMMA_EN
    return (d * d + (1 << bits) - 1) >> bits;
`else
    return d + 0 * bits;
`endif
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic void push4(input int p, input int r,
                                input int g, input int b);
    exp_t e;
    e.p = p; e.r = gm(r, 4); e.g = gm(g, 4); e.b = gm(b, 4);
    q.push_back(e);
  endfunction

  function automatic void push8(input int p, input int r,
                                input int g, input int b);
    exp_t e;
    e.p = p; e.r = gm(r, 8); e.g = gm(g, 8); e.b = gm(b, 8);
    q8.push_back(e);
  endfunction

  task automatic send4(input int r, input int g, input int b,
                       output int ac);
    int k;
    @(posedge clk); #1;
    r_in = 4'(r); g_in = 4'(g); b_in = 4'(b);
    in_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("send_ready", int'(in_ready), 1);
    ac = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    int k;
    k = 0;
    while (cyc < n && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("wait_bound", int'(cyc >= n), 1);
  endtask

  // Monitor for the 4-bit instance. A period's samples are the
  // 16 cycles after its frame_start, ending on the next frame_start.
  initial begin : mon4
    int pidx, ns, lr, lg, lb;
    bit open;
    exp_t e;
    pidx = 0; open = 0; ns = 0; lr = 0; lg = 0; lb = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pidx = 0;
        open = 0;
      end else begin
        if (open) begin
          ns++;
          if (!RGB_R) lr++;
          if (!RGB_G) lg++;
          if (!RGB_B) lb++;
        end
        if (frame_start) begin
          chk("frame_cyc", cyc, 16 * (pidx + 1));
          if (open && q.size() > 0 && q[0].p <= pidx) begin
            e = q.pop_front();
            chk("period_tag", pidx, e.p);
            chk("r_low", lr, e.r);
            chk("g_low", lg, e.g);
            chk("b_low", lb, e.b);
            chk("samples", ns, 16);
          end
          pidx++;
          open = 1;
          ns = 0; lr = 0; lg = 0; lb = 0;
        end
      end
    end
  end

  initial begin : mon8
    int pidx, ns, lr, lg, lb;
    bit open;
    exp_t e;
    pidx = 0; open = 0; ns = 0; lr = 0; lg = 0; lb = 0;
    forever begin
      @(negedge clk);
      if (rst8) begin
        pidx = 0;
        open = 0;
      end else begin
        if (open) begin
          ns++;
          if (!r8o) lr++;
          if (!g8o) lg++;
          if (!b8o) lb++;
        end
        if (fs8) begin
          if (open && q8.size() > 0 && q8[0].p <= pidx) begin
            e = q8.pop_front();
            chk("u8_tag", pidx, e.p);
            chk("u8_r_low", lr, e.r);
            chk("u8_g_low", lg, e.g);
            chk("u8_b_low", lb, e.b);
            chk("u8_samples", ns, 256);
          end
          pidx++;
          open = 1;
          ns = 0; lr = 0; lg = 0; lb = 0;
        end
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0;
    r_in = '0; g_in = '0; b_in = '0;
    rst8 = 1'b1; v8 = 1'b0;
    r8 = '0; g8 = '0; b8 = '0;
    fork
      begin : seq4
        int ac, ab, p, pa, pc, pd, pe;
        repeat (3) begin
          @(negedge clk);
          chk("rst_pins", int'({RGB_R, RGB_G, RGB_B}), 7);
          chk("rst_ready", int'(in_ready), 0);
          chk("rst_fs", int'(frame_start), 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", int'(in_ready), 1);
        chk("pins_after_rst", int'({RGB_R, RGB_G, RGB_B}), 7);

        send4(4, 0, 15, ac);
        p = (ac + 1) / 16 + 1;
        push4(p, 4, 0, 15);
        push4(p + 1, 4, 0, 15);

        wait_cyc(16 * (p + 1) + 2);
        send4(10, 5, 1, ac);
        pa = (ac + 1) / 16 + 1;
        push4(pa, 10, 5, 1);
        send4(2, 14, 8, ab);
        chk("bp_accept_cyc", ab, 16 * pa);
        push4(pa + 1, 2, 14, 8);
        push4(pa + 2, 2, 14, 8);

        wait_cyc(16 * (pa + 2) - 2);
        send4(6, 9, 3, ac);
        chk("coincident_cyc", ac, 16 * (pa + 2) - 1);
        pc = pa + 3;
        push4(pc, 6, 9, 3);

        wait_cyc(16 * pc + 2);
        send4(12, 12, 12, ac);
        pd = (ac + 1) / 16 + 1;
        push4(pd, 12, 12, 12);
        wait_cyc(16 * (pd + 1) + 1);
        send4(9, 9, 9, ac);
        wait_cyc(16 * (pd + 1) + 7);
        chk("pre_rst_lit", int'({RGB_R, RGB_G, RGB_B}), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_pins", int'({RGB_R, RGB_G, RGB_B}), 7);
        chk("mid_rst_fs", int'(frame_start), 0);
        chk("mid_rst_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst2", int'(in_ready), 1);
        chk("pins_after_rst2", int'({RGB_R, RGB_G, RGB_B}), 7);
        push4(1, 0, 0, 0);
        push4(2, 0, 0, 0);
        wait_cyc(34);
        send4(7, 3, 0, ac);
        pe = (ac + 1) / 16 + 1;
        push4(pe, 7, 3, 0);
        wait_cyc(16 * (pe + 1) + 2);
      end
      begin : seq8
        int k;
        repeat (4) @(posedge clk);
        #1;
        rst8 = 1'b0;
        @(posedge clk); #1;
        r8 = 8'd128; g8 = 8'd1; b8 = 8'd255;
        v8 = 1'b1;
        @(negedge clk);
        chk("u8_ready", int'(rdy8), 1);
        @(posedge clk); #1;
        v8 = 1'b0;
        push8(1, 128, 1, 255);
        push8(2, 128, 1, 255);
        k = 0;
        while (q8.size() > 0 && k < 1200) begin
          @(negedge clk);
          k++;
        end
      end
    join
    chk("q4_drained", q.size(), 0);
    chk("q8_drained", q8.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
